fifo_ctrl_status: RTL and testbench
===================================

Name: fifo_ctrl_status

Overview:
- Parametrised FIFO controller for the median-filter line/frame buffers: owns the write and read pointers, drives the external synchronous dual-port RAM enables and addresses, and reports fill status.
- Supersedes the combinational status block, which had external pointers and a single push-or-pop per cycle.
- Adds simultaneous push and pop, an occupancy count, programmable almost-full/almost-empty levels, and sticky overflow/underflow error flags with a clear input.

Parameters:
- ADDR_WIDTH, 16, RAM address width; DEPTH = 2**ADDR_WIDTH entries (65536 = one 256x256 frame).
- AFULL_LEVEL, 65280, almost_full asserts when count >= AFULL_LEVEL (one 256-pixel line of margin).
- AEMPTY_LEVEL, 256, almost_empty asserts when count <= AEMPTY_LEVEL.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ff_en  in  1  global enable; when 0, no push or pop is accepted and no error is flagged.
- push  in  1  write request this cycle.
- pop  in  1  read request this cycle.
- clr_err  in  1  clears the sticky overflow and underflow flags.
- ff_we  out  1  RAM write enable (accepted push).
- ff_re  out  1  RAM read enable (accepted pop).
- waddr  out  ADDR_WIDTH  RAM write address.
- raddr  out  ADDR_WIDTH  RAM read address.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Pointers: wptr and rptr are internal registers of ADDR_WIDTH+1 bits. The MSB is the wrap bit.
  - waddr = wptr[ADDR_WIDTH-1:0]; raddr = rptr[ADDR_WIDTH-1:0].
- Flags derive from registered pointers only:
  - empty: pointers fully equal.
  - full: low bits equal and MSBs differ.
  - count = (wptr - rptr) modulo 2**(ADDR_WIDTH+1).
  - full, empty, almost_full, almost_empty and count are combinational from the pointer registers, so they reflect state after the last edge.
- Acceptance (combinational, same cycle as the request):
  - ff_we = ff_en & push & ~full.
  - ff_re = ff_en & pop & ~empty.
- Pointer update on a clock edge:
  - wptr += 1 if ff_we; rptr += 1 if ff_re.
  - Both may advance in the same cycle; count is then unchanged.
  - Increment wraps naturally through the MSB (2**(ADDR_WIDTH+1) - 1 -> 0).
- No pass-through:
  - When full, a push is rejected even if a pop is accepted in the same cycle.
  - When empty, a pop is rejected even if a push is accepted in the same cycle.
- Read latency: raddr and ff_re are presented in cycle N. The synchronous RAM returns data in cycle N+1, which is outside this block.
- Errors:
  - overflow is set on an edge where ff_en & push & full.
  - underflow is set on an edge where ff_en & pop & empty.
  - Both flags hold until clr_err = 1 or rst.
  - If clr_err and a new error occur in the same cycle, set wins and the flag stays 1.
  - A rejected request has no other side effect.
- Reset (synchronous, mid-operation included): wptr = rptr = 0, overflow = underflow = 0. Resulting outputs:
  - empty = 1, full = 0, count = 0.
  - almost_empty = 1, almost_full = 0.
  - ff_we = ff_re = 0, waddr = raddr = 0.
  - A push or pop in the reset cycle is ignored.
- Parameter legality: 0 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH. Elaboration is not required to check this.

Test Plan (run with ADDR_WIDTH=2, DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1 unless noted):
- Reset then idle:
  - empty=1, almost_empty=1, count=0, ff_we=ff_re=0.
  - Pulsing rst mid-fill at count=3 returns these values on the next cycle.
- Fill from empty (4 pushes, ff_en=1):
  - waddr goes 0,1,2,3.
  - count goes 1,2,3,4.
  - almost_empty clears at count=2; almost_full sets at count=3; full sets at count=4.
  - A fifth push gives ff_we=0, count stays 4, overflow=1.
- Drain (4 pops):
  - raddr goes 0,1,2,3 and empty=1 at the end.
  - A fifth pop gives ff_re=0 and underflow=1.
  - clr_err=1 clears both flags; a simultaneous clr_err with a new pop-while-empty keeps underflow=1.
- Simultaneous push and pop at count=2 for 10 cycles:
  - count stays 2.
  - Pointers wrap past the MSB: waddr/raddr cycle through 0..3 with empty/full never asserted.
- Push+pop while full: ff_re=1, ff_we=0, count goes 4 -> 3. Push+pop while empty: ff_we=1, ff_re=0, count goes 0 -> 1.
- ff_en=0 with push=pop=1 in full and in empty states: no pointer change, no overflow/underflow set, ff_we=ff_re=0.

Source files
------------

// File: rtl/fifo_ctrl_status.sv
// FIFO controller: owns write/read pointers for an external synchronous dual-port RAM
// and reports occupancy, threshold flags and sticky overflow/underflow errors.
module fifo_ctrl_status #(
  parameter int ADDR_WIDTH   = 16,
  parameter int AFULL_LEVEL  = 65280,
  parameter int AEMPTY_LEVEL = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ff_en,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  ff_we,
  output logic                  ff_re,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wptr_reg;
  logic [ADDR_WIDTH:0] rptr_reg;
  logic                overflow_reg;
  logic                underflow_reg;
  logic                push_err;
  logic                pop_err;

  // Extra MSB distinguishes full from empty when the low address bits match.
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[ADDR_WIDTH-1:0] == rptr_reg[ADDR_WIDTH-1:0]) &&
                 (wptr_reg[ADDR_WIDTH] != rptr_reg[ADDR_WIDTH]);
  assign count = wptr_reg - rptr_reg;

  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // No pass-through: acceptance looks only at registered state, never at the other port.
  // Requests in a reset cycle are ignored, so the RAM must not see an enable either.
  assign ff_we = ff_en & push & ~full  & ~rst;
  assign ff_re = ff_en & pop  & ~empty & ~rst;

  assign push_err = ff_en & push & full;
  assign pop_err  = ff_en & pop  & empty;

  assign waddr     = wptr_reg[ADDR_WIDTH-1:0];
  assign raddr     = rptr_reg[ADDR_WIDTH-1:0];
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (ff_we) wptr_reg <= wptr_reg + 1'b1;
      if (ff_re) rptr_reg <= rptr_reg + 1'b1;

      // A new error in the same cycle as clr_err keeps the flag set.
      if (push_err)     overflow_reg <= 1'b1;
      else if (clr_err) overflow_reg <= 1'b0;

      if (pop_err)      underflow_reg <= 1'b1;
      else if (clr_err) underflow_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_status.sv
// Scoreboard bench for fifo_ctrl_status (ADDR_WIDTH=2): directed corner cases then random traffic
// checked against an occupancy/index model; a negedge monitor pops expectations and compares.
module tb_fifo_ctrl_status;

  localparam int AW     = 2;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;

  logic          clk = 1'b0;
  logic          rst, ff_en, push, pop, clr_err;
  logic          ff_we, ff_re, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW-1:0] waddr, raddr;
  logic [AW:0]   count;

  fifo_ctrl_status #(
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFULL),
    .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ff_en       (ff_en),
    .push        (push),
    .pop         (pop),
    .clr_err     (clr_err),
    .ff_we       (ff_we),
    .ff_re       (ff_re),
    .waddr       (waddr),
    .raddr       (raddr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, en, pu, po, cl;
    int we, re, waddr, raddr, count, full, empty, af, ae, ovf, unf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference model: occupancy plus total writes/reads issued, sticky error bits.
  int m_cnt = 0, m_wr = 0, m_rd = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL txn %0d %s: got %0d expected %0d", n_txn, name, got, expv);
    end
  endtask

  task automatic cyc(input int r, input int en, input int pu, input int po, input int cl);
    exp_t e;
    rst = r[0]; ff_en = en[0]; push = pu[0]; pop = po[0]; clr_err = cl[0];
    e.r = r; e.en = en; e.pu = pu; e.po = po; e.cl = cl;
    e.count = m_cnt;
    e.full  = (m_cnt == DEPTH);
    e.empty = (m_cnt == 0);
    e.af    = (m_cnt >= AFULL);
    e.ae    = (m_cnt <= AEMPTY);
    e.we    = (r == 0 && en != 0 && pu != 0 && m_cnt < DEPTH);
    e.re    = (r == 0 && en != 0 && po != 0 && m_cnt > 0);
    e.waddr = m_wr % DEPTH;
    e.raddr = m_rd % DEPTH;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb.push_back(e);
    @(posedge clk);
    if (r != 0) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_cnt = m_cnt + e.we - e.re;
      m_wr  = m_wr + e.we;
      m_rd  = m_rd + e.re;
      if (en != 0 && pu != 0 && e.full != 0) m_ovf = 1;
      else if (cl != 0)                      m_ovf = 0;
      if (en != 0 && po != 0 && e.empty != 0) m_unf = 1;
      else if (cl != 0)                       m_unf = 0;
    end
    #1;
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_txn++;
        $display("txn %0d rst=%0d en=%0d push=%0d pop=%0d clr=%0d | we=%0d re=%0d wa=%0d ra=%0d cnt=%0d f=%0d e=%0d af=%0d ae=%0d ovf=%0d unf=%0d",
                 n_txn, e.r, e.en, e.pu, e.po, e.cl, ff_we, ff_re, waddr, raddr, count,
                 full, empty, almost_full, almost_empty, overflow, underflow);
        chk("ff_we",        int'(ff_we),        e.we);
        chk("ff_re",        int'(ff_re),        e.re);
        chk("waddr",        int'(waddr),        e.waddr);
        chk("raddr",        int'(raddr),        e.raddr);
        chk("count",        int'(count),        e.count);
        chk("full",         int'(full),         e.full);
        chk("empty",        int'(empty),        e.empty);
        chk("almost_full",  int'(almost_full),  e.af);
        chk("almost_empty", int'(almost_empty), e.ae);
        chk("overflow",     int'(overflow),     e.ovf);
        chk("underflow",    int'(underflow),    e.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; ff_en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and idle
    repeat (2) cyc(0, 1, 0, 0, 0);
    // Fill, overflow attempt
    repeat (4) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    // Drain, underflow attempt
    repeat (4) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    // Steady push+pop at count=2 across pointer wrap
    repeat (2) cyc(0, 1, 1, 0, 0);
    repeat (10) cyc(0, 1, 1, 1, 0);
    // Push+pop while full, then while empty
    repeat (2) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0);
    // Disabled requests in empty and in full states
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    repeat (4) cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    // Reset mid-fill at count=3
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);

    // Random traffic with occasional reset and clear
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1 : 0,
          ($urandom_range(0, 7) != 0) ? 1 : 0,
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0) ? 1 : 0);
    end
    cyc(0, 1, 0, 0, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
